// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : MD-class operation encoding and default latencies shared
//               by the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [3:0] MD_NONE = 4'd0;
    localparam logic [3:0] MULT    = 4'd1;
    localparam logic [3:0] MULTU   = 4'd2;
    localparam logic [3:0] DIV     = 4'd3;
    localparam logic [3:0] DIVU    = 4'd4;
    localparam logic [3:0] MFHI    = 4'd5;
    localparam logic [3:0] MFLO    = 4'd6;
    localparam logic [3:0] MTHI    = 4'd7;
    localparam logic [3:0] MTLO    = 4'd8;
    localparam logic [3:0] MADD    = 4'd9;
    localparam logic [3:0] MADDU   = 4'd10;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Two's-complement magnitude of a 32-bit value; -2^31 maps to 0x80000000.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        mag32 = v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_core.sv
// ============================================================================
// Module      : mdu_core
// Description : Combinational 64-bit HI/LO result for the latched MD op.
//               A zero divisor returns the old HI/LO untouched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_core
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_div_zero;

    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};
    assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};

    // One unsigned divider serves both DIV and DIVU; DIV works on magnitudes
    // and fixes the signs afterwards, which also covers -2^31 / -1 cleanly.
    assign w_signed_div = (i_op == DIV);
    assign w_dvd        = w_signed_div ? mag32(i_rs) : i_rs;
    assign w_dvs        = w_signed_div ? mag32(i_rt) : i_rt;
    assign w_div_zero   = (i_rt == 32'd0);
    assign w_uq         = w_div_zero ? 32'd0 : (w_dvd / w_dvs);
    assign w_ur         = w_div_zero ? 32'd0 : (w_dvd % w_dvs);

    assign w_q = (w_signed_div && (i_rs[31] ^ i_rt[31])) ? (~w_uq + 32'd1) : w_uq;
    assign w_r = (w_signed_div && i_rs[31])              ? (~w_ur + 32'd1) : w_ur;

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        case (i_op)
            MULT:  {o_hi, o_lo} = w_prod_s;
            MULTU: {o_hi, o_lo} = w_prod_u;
            DIV, DIVU: begin
                if (!w_div_zero) begin
                    o_hi = w_r;
                    o_lo = w_q;
                end
            end
            MADD:  {o_hi, o_lo} = {i_hi, i_lo} + w_prod_s;
            MADDU: {o_hi, o_lo} = {i_hi, i_lo} + w_prod_u;
            default: begin
                o_hi = i_hi;
                o_lo = i_lo;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module      : mdu_ctrl
// Description : Multi-cycle multiply/divide controller owning HI/LO.
//               Optional macro MDU_MADD_EN enables MADD/MADDU accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] fwd1,
    input  logic [31:0] fwd2,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] v_md_out
);

    localparam int C_MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);

    localparam logic [C_CNT_W-1:0] C_MUL_LD  = C_CNT_W'(MULT_CYC);
    localparam logic [C_CNT_W-1:0] C_DIV_LD  = C_CNT_W'(DIV_CYC);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    md_state_e          r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [3:0]         r_op;
    logic [31:0]        r_rs;
    logic [31:0]        r_rt;

    logic               w_is_mul;
    logic               w_is_div;
    logic [31:0]        w_new_hi;
    logic [31:0]        w_new_lo;

`ifdef MDU_MADD_EN
    assign w_is_mul = (md_op == MULT) || (md_op == MULTU) ||
                      (md_op == MADD) || (md_op == MADDU);
`else
    assign w_is_mul = (md_op == MULT) || (md_op == MULTU);
`endif
    assign w_is_div = (md_op == DIV) || (md_op == DIVU);

    // HI/LO cannot change while RUN, so the live registers double as the
    // accumulator snapshot taken at start.
    mdu_core u_core (
        .i_op (r_op),
        .i_rs (r_rs),
        .i_rt (r_rt),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_new_hi),
        .o_lo (w_new_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_op    <= MD_NONE;
            r_rs    <= 32'd0;
            r_rt    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (md_valid) begin
                        if (w_is_mul || w_is_div) begin
                            r_op    <= md_op;
                            r_rs    <= fwd1;
                            r_rt    <= fwd2;
                            r_cnt   <= w_is_div ? C_DIV_LD : C_MUL_LD;
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN;
                        end else if (md_op == MTHI) begin
                            r_hi <= fwd1;
                        end else if (md_op == MTLO) begin
                            r_lo <= fwd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_cnt <= C_CNT_ONE) begin
                        r_hi    <= w_new_hi;
                        r_lo    <= w_new_lo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign md_stall = md_valid && (r_state == ST_RUN);

    always_comb begin
        v_md_out = 32'd0;
        if (md_op == MFHI) begin
            v_md_out = r_hi;
        end else if (md_op == MFLO) begin
            v_md_out = r_lo;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl against an arithmetic model.
//               Honours MDU_MADD_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;
    import mdu_pkg::*;

`ifdef MDU_MADD_EN
    localparam bit C_MADD_ON = 1'b1;
`else
    localparam bit C_MADD_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [3:0]  md_op;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] v_md_out;

    int          n_checks;
    int          n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_valid (md_valid),
        .md_op    (md_op),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .v_md_out (v_md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [3:0] op);
        if (op == MULT || op == MULTU) return 5;
        if (op == DIV || op == DIVU) return 10;
        if (op == MADD || op == MADDU) return C_MADD_ON ? 5 : 0;
        return 0;
    endfunction

    // Architectural effect of one accepted instruction on HI/LO.
    task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {m_hi, m_lo};
        case (op)
            MULT:  {m_hi, m_lo} = 64'(sa * sb);
            MULTU: {m_hi, m_lo} = 64'({32'd0, a}) * 64'({32'd0, b});
            DIV:   if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            DIVU:  if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            MTHI:  m_hi = a;
            MTLO:  m_lo = a;
            MADD:  if (C_MADD_ON) {m_hi, m_lo} = acc + 64'(sa * sb);
            MADDU: if (C_MADD_ON) {m_hi, m_lo} = acc + 64'({32'd0, a}) * 64'({32'd0, b});
            default: ;
        endcase
    endtask

    // Present one instruction for a single cycle, starting at edge+1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_valid = 1'b1;
        md_op    = op;
        fwd1     = a;
        fwd2     = b;
        @(posedge clk); #1;
        md_valid = 1'b0;
        md_op    = MD_NONE;
        model_exec(op, a, b);
    endtask

    // Count busy cycles while scrambling operands; bounded at 100 cycles.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            fwd1 = $urandom;
            fwd2 = $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        md_valid = 1'b1;
        md_op    = MULT;
        fwd1     = 32'd3;
        fwd2     = 32'd3;
        #3;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        @(posedge clk); #1;
        n_checks++;
        if (md_stall !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: md_stall=%b busy=%b required 0/0", md_stall, busy);
        end
        md_op = MFHI;
        #1;
        n_checks++;
        if (v_md_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mdout: v_md_out=%h required 0", v_md_out);
        end
        md_valid = 1'b0;
        md_op    = MD_NONE;
        #2 reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        int n;
        issue(MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        n_checks++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL mult_busy: cycles=%0d required 5", n);
        end
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mult_result: hi=%h lo=%h required ffffffff/fffffffe", hi, lo);
        end
    endtask

    task automatic test_divu_mflo;
        int n;
        issue(DIVU, 32'd7, 32'd2);
        md_valid = 1'b1;
        md_op    = MFLO;
        n = 0;
        #1;
        while (md_stall && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (n !== 10) begin
            n_fail++;
            $display("FAIL divu_stall: cycles=%0d required 10", n);
        end
        n_checks++;
        if (v_md_out !== 32'd3 || hi !== 32'd1) begin
            n_fail++;
            $display("FAIL divu_mflo: v_md_out=%h hi=%h required 3/1", v_md_out, hi);
        end
        md_valid = 1'b0;
        md_op    = MD_NONE;
    endtask

    task automatic test_div_signed;
        int n;
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        n_checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_neg: hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
        end
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        n_checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL div_ovf: hi=%h lo=%h required 0/80000000", hi, lo);
        end
    endtask

    task automatic test_div_zero;
        int n;
        logic [31:0] old_lo;
        issue(MTHI, 32'h1234_5678, 32'd0);
        old_lo = m_lo;
        issue(DIV, 32'd99, 32'd0);
        wait_idle(n);
        n_checks++;
        if (n !== 10 || hi !== 32'h1234_5678 || lo !== old_lo) begin
            n_fail++;
            $display("FAIL div_zero: cycles=%0d hi=%h lo=%h required 10/12345678/%h", n, hi, lo, old_lo);
        end
    endtask

    task automatic test_run_ignore;
        int n;
        issue(MULTU, 32'd1000, 32'd3000);
        md_valid = 1'b1;
        md_op    = MTLO;
        fwd1     = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (md_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL run_stall: md_stall=%b required 1", md_stall);
        end
        md_op = MD_NONE;
        #1;
        n_checks++;
        if (md_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL run_stall_none: md_stall=%b required 1", md_stall);
        end
        md_op = MTLO;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        md_valid = 1'b0;
        md_op    = MD_NONE;
        n_checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL run_ignore: hi=%h lo=%h required %h/%h", hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_midop;
        issue(MTHI, 32'hAAAA_5555, 32'd0);
        issue(MULT, 32'd12345, 32'd678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset    = 1'b0;
        md_valid = 1'b1;
        md_op    = MFHI;
        #1;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        n_checks++;
        if (md_stall !== 1'b0 || v_md_out !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_outs: md_stall=%b v_md_out=%h required 0/0", md_stall, v_md_out);
        end
        md_valid = 1'b0;
        md_op    = MD_NONE;
        #2 reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_after: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_madd;
        int n;
        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'd5, 32'd0);
        issue(MADD, 32'd3, 32'd4);
        wait_idle(n);
        n_checks++;
        if (n !== (C_MADD_ON ? 5 : 0)) begin
            n_fail++;
            $display("FAIL madd_busy: cycles=%0d required %0d", n, C_MADD_ON ? 5 : 0);
        end
        n_checks++;
        if (lo !== (C_MADD_ON ? 32'd17 : 32'd5) || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL madd_result: hi=%h lo=%h required 0/%0d", hi, lo, C_MADD_ON ? 17 : 5);
        end
    endtask

    task automatic test_random;
        int          n;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            md_op = op;
            #1;
            want = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
            n_checks++;
            if (v_md_out !== want) begin
                n_fail++;
                $display("FAIL rnd_mdout[%0d]: op=%0d v_md_out=%h required %h", i, op, v_md_out, want);
            end
            issue(op, a, b);
            wait_idle(n);
            n_checks++;
            if (n !== exp_lat(op)) begin
                n_fail++;
                $display("FAIL rnd_busy[%0d]: op=%0d cycles=%0d required %0d", i, op, n, exp_lat(op));
            end
            n_checks++;
            if (hi !== m_hi || lo !== m_lo) begin
                n_fail++;
                $display("FAIL rnd_hilo[%0d]: op=%0d a=%h b=%h hi=%h lo=%h required %h/%h",
                         i, op, a, b, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        md_valid = 1'b0;
        md_op    = MD_NONE;
        fwd1     = 32'd0;
        fwd2     = 32'd0;
        test_reset;
        test_mult;
        test_divu_mflo;
        test_div_signed;
        test_div_zero;
        test_run_ignore;
        test_madd;
        test_random;
        test_reset_midop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5: busy cycles for MULT/MULTU/MADD/MADDU.
REQ-002 SHALL have parameter DIV_CYC, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port md_valid, input, 1: the E-stage instruction is MD-class and not a bubble.
REQ-006 SHALL have port md_op, input, 4: operation code from the mdu_pkg encoding.
REQ-007 SHALL have port fwd1, input, 32: forwarded rs value.
REQ-008 SHALL have port fwd2, input, 32: forwarded rt value.
REQ-009 SHALL have port busy, output, 1: a multi-cycle operation is in progress.
REQ-010 SHALL have port md_stall, output, 1: stall request to the hazard unit.
REQ-011 SHALL have port hi, output, 32: the architectural HI register.
REQ-012 SHALL have port lo, output, 32: the architectural LO register.
REQ-013 SHALL have port v_md_out, output, 32: the MFHI/MFLO result for the E-to-M path.

Function
REQ-014 SHALL implement states IDLE and RUN, plus a down-counter cnt.
REQ-015 SHALL accept a start only when state is IDLE, md_valid=1 and md_op is MULT, MULTU, DIV or DIVU (or MADD/MADDU when enabled).
- On that edge: latch fwd1/fwd2/op, load the latency, go to RUN.
REQ-016 busy SHALL be 1 for exactly MULT_CYC or DIV_CYC consecutive cycles, starting the cycle after the start edge.
- HI/LO SHALL be written on the edge that ends the last busy cycle.
- State SHALL return to IDLE on that same edge.
REQ-017 md_stall SHALL equal md_valid AND (state==RUN); it SHALL be combinational and have no dependence on md_op.
REQ-018 MTHI/MTLO SHALL write fwd1 into HI/LO on the edge where md_valid=1 and state=IDLE.
- They are ignored while RUN, because they stall.
REQ-019 v_md_out SHALL be hi for MFHI, lo for MFLO, and 0 otherwise; it is combinational.
REQ-020 MULT SHALL place the signed 64-bit product in {hi,lo}; MULTU SHALL place the unsigned product.
REQ-021 DIV SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
- DIV -2^31 / -1 SHALL give lo=0x80000000, hi=0.
REQ-022 DIVU SHALL produce the unsigned quotient in lo and the unsigned remainder in hi.
REQ-023 A divisor of 0 SHALL still run DIV_CYC busy cycles and SHALL leave HI/LO unchanged.
REQ-024 md_op=MD_NONE, or an undefined code, with md_valid=1 SHALL change no state.
REQ-025 Operand values SHALL be those latched at start; input changes during RUN SHALL have no effect.

Reset
REQ-026 reset=0 SHALL immediately force the following, regardless of the clock:
- state=IDLE, cnt=0, busy=0, hi=0, lo=0.
- Any in-flight operation is discarded.
REQ-027 During reset, md_stall=0 and v_md_out=0.

Configuration
REQ-028 With MDU_MADD_EN defined, MADD SHALL perform {hi,lo} += signed(fwd1*fwd2) and MADDU SHALL perform {hi,lo} += unsigned(fwd1*fwd2).
- Both use MULT_CYC latency; the addition wraps modulo 2^64.
- The accumulator value used is the one latched at start.
REQ-029 Without MDU_MADD_EN, MADD/MADDU codes SHALL be treated as MD_NONE: no start, no busy, no change to HI/LO.

Structure
REQ-030 mdu_pkg SHALL hold the op encoding and the default latencies MULT_CYC_DEF=5 and DIV_CYC_DEF=10.
- Encoding: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10.
REQ-031 The 64-bit result SHALL be computed in one sub-module, mdu_core.
- mdu_core is combinational: latched op and operands plus old {hi,lo} in, new {hi,lo} out.
- mdu_ctrl owns the FSM, the counter and the HI/LO registers.

Verification
REQ-032 MULT fwd1=0xFFFFFFFF, fwd2=2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 DIVU 7/2, then MFLO presented the next cycle -> md_stall=1 for 10 cycles, then v_md_out=3; hi=1.
REQ-034 DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 MTHI 0x12345678 then DIV x/0 -> busy 10 cycles; hi remains 0x12345678, lo unchanged.
REQ-036 reset driven low in the 3rd busy cycle of a MULT -> busy, hi and lo read 0 before the next clock edge; no write occurs after release.
REQ-037 Build with MDU_MADD_EN: {hi,lo}=0:5, MADD 3,4 -> lo=17 after 5 cycles. Build without it: the same stimulus gives busy=0 throughout and lo=5.
